// File: rtl/oled_pkg.sv
// oled_seq shared definitions: entry opcodes, pin-action codes,
// FSM state codes and ROM entry helpers.
package oled_pkg;

    typedef enum logic [1:0] {
        OP_SPI = 2'b00,
        OP_PIN = 2'b01,
        OP_DLY = 2'b10,
        OP_END = 2'b11
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [7:0] arg;
    } entry_t;

    localparam logic [2:0] PIN_VDD_ON  = 3'd0;
    localparam logic [2:0] PIN_VDD_OFF = 3'd1;
    localparam logic [2:0] PIN_RST_ASR = 3'd2;
    localparam logic [2:0] PIN_RST_REL = 3'd3;
    localparam logic [2:0] PIN_VBAT_ON = 3'd4;
    localparam logic [2:0] PIN_VBAT_OFF = 3'd5;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_DECODE = 3'd2;
    localparam state_t S_SPI    = 3'd3;
    localparam state_t S_PIN    = 3'd4;
    localparam state_t S_DLY    = 3'd5;
    localparam state_t S_NEXT   = 3'd6;
    localparam state_t S_DONE   = 3'd7;

    function automatic logic [9:0] e_spi(input logic [7:0] b);
        return {OP_SPI, b};
    endfunction

    function automatic logic [9:0] e_pin(input logic [2:0] c);
        return {OP_PIN, 5'd0, c};
    endfunction

    function automatic logic [9:0] e_dly(input logic [7:0] ms);
        return {OP_DLY, ms};
    endfunction

    function automatic logic [9:0] e_end();
        return {OP_END, 8'd0};
    endfunction

endpackage

// File: rtl/oled_seq_if.sv
// Control handshake between top-level control and the sequencer.
// master = controller side, slave = oled_seq.
interface oled_seq_if;
    import oled_pkg::*;

    logic start_up;
    logic start_down;
    logic busy;
    logic fin;
    logic err;

    modport master (
        output start_up, start_down,
        input  busy, fin, err
    );

    modport slave (
        input  start_up, start_down,
        output busy, fin, err
    );

endinterface

// File: rtl/oled_spi_tx.sv
// SPI mode-3 byte shifter, MSB first; sclk idles high.
// done pulses combinationally in the final cycle of the byte.
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int SPI_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data,
    output logic       sclk,
    output logic       sdo,
    output logic       done
);

    localparam int DW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

    logic          active;
    logic [DW-1:0] div;
    logic [3:0]    half;
    logic [7:0]    sh;
    logic          last_div;

    assign last_div = (div == DW'(SPI_DIV - 1));
    assign done     = active && last_div && (half == 4'd15);

    // Even halves hold sclk low (sdo changes on their leading edge),
    // odd halves hold sclk high; half 15 ends the byte with sclk high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            div    <= '0;
            half   <= '0;
            sh     <= '0;
            sclk   <= 1'b1;
            sdo    <= 1'b0;
        end else if (en) begin
            active <= 1'b1;
            div    <= '0;
            half   <= '0;
            sclk   <= 1'b0;
            sdo    <= data[7];
            sh     <= {data[6:0], 1'b0};
        end else if (active) begin
            if (!last_div) begin
                div <= div + DW'(1);
            end else begin
                div <= '0;
                if (half == 4'd15) begin
                    active <= 1'b0;
                end else begin
                    half <= half + 4'd1;
                    if (half[0]) begin
                        sclk <= 1'b0;
                        sdo  <= sh[7];
                        sh   <= {sh[6:0], 1'b0};
                    end else begin
                        sclk <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/oled_seq.sv
// Table-driven OLED power-up/power-down sequencer: replays ROM
// entries (SPI byte, pin action, ms delay, END) to the panel pins.
module oled_seq
    import oled_pkg::*;
#(
    parameter int CLK_PER_MS = 100_000,
    parameter int SPI_DIV    = 4,
    parameter int SEQ_DEPTH  = 32,
    parameter int DOWN_BASE  = 24,
    parameter bit ROM_OVR_EN = 1'b0,
    parameter logic [SEQ_DEPTH*10-1:0] ROM_OVR = '0
) (
    input  logic       clk,
    input  logic       rst,
    oled_seq_if.slave  ctl,
    output logic       dc,
    output logic       res,
    output logic       vbat,
    output logic       vdd,
    output logic       sclk,
    output logic       sdo
);

    localparam int AW     = $clog2(SEQ_DEPTH);
    localparam int CW     = $clog2(255 * CLK_PER_MS + 1);
    localparam int UP_LEN = 20;
    localparam int DN_LEN = 5;
    localparam int UW     = $clog2(UP_LEN);
    localparam int NW     = $clog2(DN_LEN);

    localparam logic [9:0] UP_LIST [UP_LEN] = '{
        e_pin(PIN_VDD_ON), e_dly(8'd1), e_spi(8'hAE),
        e_pin(PIN_RST_ASR), e_dly(8'd1), e_pin(PIN_RST_REL),
        e_spi(8'h8D), e_spi(8'h14), e_spi(8'hD9), e_spi(8'hF1),
        e_pin(PIN_VBAT_ON), e_dly(8'd100),
        e_spi(8'h81), e_spi(8'h0F), e_spi(8'hA1), e_spi(8'hC8),
        e_spi(8'hDA), e_spi(8'h20), e_spi(8'hAF), e_end()
    };

    localparam logic [9:0] DN_LIST [DN_LEN] = '{
        e_spi(8'hAE), e_pin(PIN_VBAT_OFF), e_dly(8'd100),
        e_pin(PIN_VDD_OFF), e_end()
    };

    function automatic logic [SEQ_DEPTH*10-1:0] build_rom();
        logic [SEQ_DEPTH*10-1:0] r;
        for (int i = 0; i < SEQ_DEPTH; i++) r[i*10 +: 10] = e_end();
        for (int j = 0; j < UP_LEN; j++) r[j*10 +: 10] = UP_LIST[UW'(j)];
        for (int j = 0; j < DN_LEN; j++)
            r[(DOWN_BASE+j)*10 +: 10] = DN_LIST[NW'(j)];
        return r;
    endfunction

    localparam logic [SEQ_DEPTH*10-1:0] ROM_BITS =
        ROM_OVR_EN ? ROM_OVR : build_rom();

    state_t        state;
    logic [AW-1:0] ptr;
    entry_t        ent;
    logic [CW-1:0] cnt;
    logic          spi_en;
    logic          spi_done;

    // SPI launch coincides with the edge leaving DECODE so the SPI
    // state lasts exactly one byte time.
    assign spi_en = (state == S_DECODE) && (ent.op == OP_SPI);

    oled_spi_tx #(.SPI_DIV(SPI_DIV)) u_spi (
        .clk  (clk),
        .rst  (rst),
        .en   (spi_en),
        .data (ent.arg),
        .sclk (sclk),
        .sdo  (sdo),
        .done (spi_done)
    );

    // Sequencer FSM: fetch/decode/execute one ROM entry at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            ent        <= '0;
            cnt        <= '0;
            ctl.busy   <= 1'b0;
            ctl.fin    <= 1'b0;
            ctl.err    <= 1'b0;
            dc         <= 1'b0;
            res        <= 1'b1;
            vbat       <= 1'b1;
            vdd        <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (ctl.start_up || ctl.start_down) begin
                        ptr      <= ctl.start_down ? AW'(DOWN_BASE) : '0;
                        ctl.fin  <= 1'b0;
                        ctl.busy <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ent   <= entry_t'(ROM_BITS[int'(ptr)*10 +: 10]);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    unique case (ent.op)
                        OP_SPI: begin
                            dc    <= 1'b0;
                            state <= S_SPI;
                        end
                        OP_PIN: state <= S_PIN;
                        OP_DLY: begin
                            if (ent.arg == 8'd0) begin
                                state <= S_NEXT;
                            end else begin
                                cnt   <= CW'(ent.arg) * CW'(CLK_PER_MS)
                                         - CW'(1);
                                state <= S_DLY;
                            end
                        end
                        OP_END: begin
                            ctl.busy <= 1'b0;
                            ctl.fin  <= 1'b1;
                            state    <= S_DONE;
                        end
                    endcase
                end
                S_SPI: begin
                    if (spi_done) state <= S_NEXT;
                end
                S_PIN: begin
                    case (ent.arg[2:0])
                        PIN_VDD_ON:   vdd  <= 1'b0;
                        PIN_VDD_OFF:  vdd  <= 1'b1;
                        PIN_RST_ASR:  res  <= 1'b0;
                        PIN_RST_REL:  res  <= 1'b1;
                        PIN_VBAT_ON:  vbat <= 1'b0;
                        PIN_VBAT_OFF: vbat <= 1'b1;
                        default: ;
                    endcase
                    state <= S_NEXT;
                end
                S_DLY: begin
                    if (cnt == '0) state <= S_NEXT;
                    else cnt <= cnt - CW'(1);
                end
                S_NEXT: begin
                    if (ptr == AW'(SEQ_DEPTH - 1)) begin
                        ctl.err  <= 1'b1;
                        ctl.busy <= 1'b0;
                        ctl.fin  <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        ptr   <= ptr + AW'(1);
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_seq.sv
// Directed bench for oled_seq: power-up/down lists, start collisions,
// missing-END error and reset in the middle of an SPI byte.
module tb_oled_seq;
    import oled_pkg::*;

    localparam int CPM = 10;
    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter, bumped before any DUT register update at that edge.
    always @(posedge clk) cyc++;

    oled_seq_if u_if ();
    oled_seq_if e_if ();

    logic dc, res, vbat, vdd, sclk, sdo;
    logic e_dc, e_res, e_vbat, e_vdd, e_sclk, e_sdo;

    oled_seq #(.CLK_PER_MS(CPM), .SPI_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .ctl(u_if),
        .dc(dc), .res(res), .vbat(vbat), .vdd(vdd),
        .sclk(sclk), .sdo(sdo)
    );

    oled_seq #(
        .CLK_PER_MS(CPM), .SPI_DIV(DIV),
        .ROM_OVR_EN(1'b1), .ROM_OVR({32{10'h107}})
    ) dut_e (
        .clk(clk), .rst(rst), .ctl(e_if),
        .dc(e_dc), .res(e_res), .vbat(e_vbat), .vdd(e_vdd),
        .sclk(e_sclk), .sdo(e_sdo)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    byte unsigned rx_q[$];
    logic         dc_q[$];
    int           start_q[$];
    logic [7:0]   sh;
    int           bits = 0;

    // Byte start time: sclk falls while no bits are captured yet.
    always @(negedge sclk) if (!rst && bits == 0) start_q.push_back(cyc);

    // Mode-3 receiver: sample sdo on sclk rising edge.
    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            bits = 0;
        end else begin
            sh = {sh[6:0], sdo};
            bits++;
            if (bits == 8) begin
                rx_q.push_back(sh);
                dc_q.push_back(dc);
                bits = 0;
            end
        end
    end

    int t_vdd_fall, t_vdd_rise, t_res_fall, t_res_rise;
    int t_vbat_fall, t_vbat_rise, t_busy_rise, t_busy_fall;
    int t_ebusy_rise, t_ebusy_fall;

    always @(negedge vdd)       t_vdd_fall   = cyc;
    always @(posedge vdd)       t_vdd_rise   = cyc;
    always @(negedge res)       t_res_fall   = cyc;
    always @(posedge res)       t_res_rise   = cyc;
    always @(negedge vbat)      t_vbat_fall  = cyc;
    always @(posedge vbat)      t_vbat_rise  = cyc;
    always @(posedge u_if.busy) t_busy_rise  = cyc;
    always @(negedge u_if.busy) t_busy_fall  = cyc;
    always @(posedge e_if.busy) t_ebusy_rise = cyc;
    always @(negedge e_if.busy) t_ebusy_fall = cyc;

    byte unsigned up_exp[$] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

    task automatic clear_mon();
        rx_q.delete();
        dc_q.delete();
        start_q.delete();
    endtask

    task automatic go(input logic up, input logic dn);
        @(negedge clk);
        u_if.start_up   = up;
        u_if.start_down = dn;
        @(negedge clk);
        u_if.start_up   = 1'b0;
        u_if.start_down = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (u_if.busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 4000) ? 1 : 0, 1);
    endtask

    task automatic wait_e_idle(input string tag);
        int n = 0;
        while (e_if.busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 1000) ? 1 : 0, 1);
    endtask

    task automatic check_up_list(input string tag);
        check({tag, "_nbytes"}, rx_q.size(), up_exp.size());
        for (int i = 0; i < up_exp.size(); i++) begin
            if (i < rx_q.size()) begin
                check($sformatf("%s_byte%0d", tag, i), rx_q[i], up_exp[i]);
                check($sformatf("%s_dc%0d", tag, i), dc_q[i], 0);
            end
        end
        check({tag, "_busy_len"}, t_busy_fall - t_busy_rise, 1467);
        check({tag, "_fin"}, u_if.fin, 1);
    endtask

    initial begin
        int n;
        u_if.start_up   = 1'b0;
        u_if.start_down = 1'b0;
        e_if.start_up   = 1'b0;
        e_if.start_down = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", u_if.busy, 0);
        check("rst_fin", u_if.fin, 0);
        check("rst_err", u_if.err, 0);
        check("rst_dc", dc, 0);
        check("rst_res", res, 1);
        check("rst_vbat", vbat, 1);
        check("rst_vdd", vdd, 1);
        check("rst_sclk", sclk, 1);
        check("rst_sdo", sdo, 0);
        check("rst_e_err", e_if.err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Power-up, with an extra start while busy that must be ignored.
        clear_mon();
        go(1'b1, 1'b0);
        check("up_busy", u_if.busy, 1);
        check("up_fin0", u_if.fin, 0);
        repeat (50) @(negedge clk);
        go(1'b1, 1'b0);
        wait_idle("up_timeout");
        check_up_list("up");
        check("up_err", u_if.err, 0);
        if (start_q.size() > 5) begin
            check("up_vdd_first", (t_vdd_fall < start_q[0]) ? 1 : 0, 1);
            check("up_vbat_to_81", start_q[5] - t_vbat_fall, 1006);
        end else begin
            check("up_nstarts", start_q.size(), 12);
        end
        check("up_res_low", t_res_rise - t_res_fall, 17);
        check("up_pins", {29'd0, vdd, res, vbat}, 32'b010);

        // Power-down.
        clear_mon();
        go(1'b0, 1'b1);
        check("dn_busy", u_if.busy, 1);
        check("dn_fin0", u_if.fin, 0);
        wait_idle("dn_timeout");
        check("dn_nbytes", rx_q.size(), 1);
        if (rx_q.size() > 0) check("dn_byte0", rx_q[0], 8'hAE);
        if (start_q.size() > 0)
            check("dn_ae_before_vbat", (start_q[0] < t_vbat_rise) ? 1 : 0, 1);
        check("dn_vbat_to_vdd", t_vdd_rise - t_vbat_rise, 1007);
        check("dn_pins", {30'd0, vdd, vbat}, 32'b11);
        check("dn_fin", u_if.fin, 1);
        check("dn_busy_len", t_busy_fall - t_busy_rise, 1048);

        // Simultaneous starts: the down list wins.
        clear_mon();
        go(1'b1, 1'b1);
        wait_idle("col_timeout");
        check("col_nbytes", rx_q.size(), 1);
        if (rx_q.size() > 0) check("col_byte0", rx_q[0], 8'hAE);
        check("col_busy_len", t_busy_fall - t_busy_rise, 1048);
        check("col_vdd", vdd, 1);

        // Reset in the middle of byte 0xD9.
        clear_mon();
        go(1'b1, 1'b0);
        n = 0;
        while (rx_q.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_timeout", (n < 2000) ? 1 : 0, 1);
        repeat (20) @(negedge clk);
        check("mid_in_d9", start_q.size(), 4);
        check("mid_vdd_pre", vdd, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_sclk", sclk, 1);
        check("mid_pins", {29'd0, vdd, vbat, res}, 32'b111);
        check("mid_busy", u_if.busy, 0);
        check("mid_fin", u_if.fin, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_nbytes_after", rx_q.size(), 3);
        clear_mon();
        go(1'b1, 1'b0);
        wait_idle("re_timeout");
        check_up_list("re");

        // Missing END: runs off the ROM end.
        @(negedge clk);
        e_if.start_up = 1'b1;
        @(negedge clk);
        e_if.start_up = 1'b0;
        check("e_busy", e_if.busy, 1);
        wait_e_idle("e_timeout");
        check("e_err", e_if.err, 1);
        check("e_fin", e_if.fin, 1);
        check("e_busy_done", e_if.busy, 0);
        check("e_busy_len", t_ebusy_fall - t_ebusy_rise, 128);
        @(negedge clk);
        e_if.start_down = 1'b1;
        @(negedge clk);
        e_if.start_down = 1'b0;
        check("e2_busy", e_if.busy, 1);
        check("e2_fin0", e_if.fin, 0);
        check("e2_err_sticky", e_if.err, 1);
        wait_e_idle("e2_timeout");
        check("e2_err", e_if.err, 1);
        check("e2_busy_len", t_ebusy_fall - t_ebusy_rise, 32);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
